// File: rtl/ppi_mac_tdm.sv
// Time-division polyphase interpolator: each accepted sample produces L outputs, one per
// phase, from a single shared multiply-accumulate pass over the K-deep delay line.
module ppi_mac_tdm #(
    parameter int gp_data_width           = 8,
    parameter int gp_coeff_width          = 8,
    parameter int gp_interpolation_factor = 4,
    parameter int gp_taps_per_phase       = 4,
    parameter logic [gp_interpolation_factor*gp_taps_per_phase*gp_coeff_width-1:0] gp_coeff =
        128'h100F0E0D0C0B0A090807060504030201,
    parameter int gp_out_width            = 16,
    parameter int gp_out_shift            = 0,
    parameter int gp_round                = 0,
    parameter int gp_saturate             = 1
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_an,
    input  logic                                       i_ena,
    input  logic                                       i_valid,
    input  logic signed [gp_data_width-1:0]            i_data,
    output logic                                       o_ready,
    output logic                                       o_valid,
    output logic signed [gp_out_width-1:0]             o_data,
    output logic [$clog2(gp_interpolation_factor)-1:0] o_phase
);

    localparam int L     = gp_interpolation_factor;
    localparam int K     = gp_taps_per_phase;
    localparam int DW    = gp_data_width;
    localparam int CW    = gp_coeff_width;
    localparam int OW    = gp_out_width;
    localparam int PW    = $clog2(L);
    localparam int ACC_W = DW + CW + $clog2(K);
    // One spare bit so the rounding constant can never overflow the accumulator.
    localparam int SUM_W = ACC_W + 32'sd1;
    localparam int EXT_W = (SUM_W > OW) ? SUM_W : OW;
    localparam int RND_SHIFT = (gp_out_shift > 32'sd0) ? (gp_out_shift - 32'sd1) : 32'sd0;

    localparam logic [PW-1:0] LAST_PHASE = PW'(L - 32'sd1);
    localparam logic signed [SUM_W-1:0] RND_C =
        ((gp_round != 32'sd0) && (gp_out_shift > 32'sd0)) ?
        ({{(SUM_W-1){1'b0}}, 1'b1} << RND_SHIFT) : {SUM_W{1'b0}};
    localparam logic [EXT_W-1:0] SAT_MAX_U = {1'b0, {(EXT_W-1){1'b1}}} >> (EXT_W - OW);
    localparam logic signed [EXT_W-1:0] SAT_MAX = SAT_MAX_U;
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX_U;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [PW-1:0]            phase_r;
    logic [PW-1:0]            phase_nxt_s;
    logic                     run_s;
    logic                     ready_s;
    logic                     accept_s;
    logic signed [DW-1:0]     x_r [K];
    logic signed [ACC_W-1:0]  acc_s;
    logic signed [SUM_W-1:0]  sum_s;
    logic signed [SUM_W-1:0]  shifted_s;
    logic signed [EXT_W-1:0]  ext_s;
    logic signed [OW-1:0]     result_s;
    logic                     valid_r;
    logic signed [OW-1:0]     data_r;
    logic [PW-1:0]            phase_out_r;

    assign ready_s  = i_ena & i_rst_an &
                      ((state_r == ST_IDLE) | ((state_r == ST_RUN) & (phase_r == LAST_PHASE)));
    assign accept_s = i_valid & ready_s;
    assign o_ready  = ready_s;
    assign o_valid  = valid_r;
    assign o_data   = data_r;
    assign o_phase  = phase_out_r;

    // State and phase register.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_r <= ST_IDLE;
            phase_r <= {PW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            phase_r <= phase_nxt_s;
        end
    end

    // Next-state logic; run_s marks an edge that emits an output.
    always_comb begin
        state_nxt_s = state_r;
        phase_nxt_s = phase_r;
        run_s       = 1'b0;
        if (i_ena) begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = ST_RUN;
                        phase_nxt_s = {PW{1'b0}};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    run_s = 1'b1;
                    if (phase_r == LAST_PHASE) begin
                        phase_nxt_s = {PW{1'b0}};
                        state_nxt_s = accept_s ? ST_RUN : ST_IDLE;
                    end else begin
                        phase_nxt_s = phase_r + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    phase_nxt_s = {PW{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Delay line, x_r[0] holds the newest sample.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int k = 0; k < K; k++) begin
                x_r[k] <= {DW{1'b0}};
            end
        end else if (accept_s) begin
            for (int k = K - 1; k > 0; k--) begin
                x_r[k] <= x_r[k-1];
            end
            x_r[0] <= i_data;
        end else begin
            for (int k = 0; k < K; k++) begin
                x_r[k] <= x_r[k];
            end
        end
    end

    // Phase-selected dot product, then round, shift and saturate/wrap.
    always_comb begin
        acc_s = {ACC_W{1'b0}};
        for (int k = 0; k < K; k++) begin
            acc_s = acc_s + (ACC_W'(x_r[k]) *
                             ACC_W'($signed(gp_coeff[(k*L + int'(phase_r))*CW +: CW])));
        end
        sum_s     = SUM_W'(acc_s) + RND_C;
        shifted_s = sum_s >>> gp_out_shift;
        ext_s     = EXT_W'(shifted_s);
        if (gp_saturate != 32'sd0) begin
            if (ext_s > SAT_MAX) begin
                result_s = SAT_MAX[OW-1:0];
            end else if (ext_s < SAT_MIN) begin
                result_s = SAT_MIN[OW-1:0];
            end else begin
                result_s = ext_s[OW-1:0];
            end
        end else begin
            result_s = ext_s[OW-1:0];
        end
    end

    // Output registers; data and phase hold whenever no output is emitted.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            valid_r     <= 1'b0;
            data_r      <= {OW{1'b0}};
            phase_out_r <= {PW{1'b0}};
        end else if (run_s) begin
            valid_r     <= 1'b1;
            data_r      <= result_s;
            phase_out_r <= phase_r;
        end else begin
            valid_r     <= 1'b0;
            data_r      <= data_r;
            phase_out_r <= phase_out_r;
        end
    end

endmodule

// File: tb/tb_ppi_mac_tdm.sv
// Bench for ppi_mac_tdm: scenario tasks plus random traffic, all checked against a
// sample-history / outputs-remaining reference model.
module tb_ppi_mac_tdm;

    localparam int L = 4;
    localparam int K = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic valid;
    logic signed [7:0]  data;
    logic ready;
    logic ovalid;
    logic signed [15:0] odata;
    logic [1:0] ophase;

    logic sat_ena;
    logic sat_valid;
    logic signed [7:0] sat_data;
    logic s_ready, s_valid, w_ready, w_valid;
    logic signed [11:0] s_data, w_data;
    logic [1:0] s_phase, w_phase;

    int hist [K];
    int rem;
    logic exp_valid;
    longint exp_data;
    int exp_phase;
    logic exp_ready;
    logic obs_ready;
    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    ppi_mac_tdm u_dut (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_valid(valid), .i_data(data),
        .o_ready(ready), .o_valid(ovalid), .o_data(odata), .o_phase(ophase)
    );

    ppi_mac_tdm #(.gp_out_width(12), .gp_saturate(1)) u_sat (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(sat_ena), .i_valid(sat_valid), .i_data(sat_data),
        .o_ready(s_ready), .o_valid(s_valid), .o_data(s_data), .o_phase(s_phase)
    );

    ppi_mac_tdm #(.gp_out_width(12), .gp_saturate(0)) u_wrap (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(sat_ena), .i_valid(sat_valid), .i_data(sat_data),
        .o_ready(w_ready), .o_valid(w_valid), .o_data(w_data), .o_phase(w_phase)
    );

    // Final scaling: clamp or wrap into a signed ow-bit range.
    function automatic longint fmap(input longint s, input int ow, input bit sat);
        longint mx = (longint'(1) << (ow - 1)) - 1;
        longint m  = longint'(1) << ow;
        longint r;
        if (sat) begin
            r = (s > mx) ? mx : ((s < -mx - 1) ? -mx - 1 : s);
        end else begin
            r = ((s % m) + m) % m;
            if (r > mx) r = r - m;
        end
        return r;
    endfunction

    // Output for phase p: sum over taps of h[k*L+p] * x[k], with h[m] = m+1.
    function automatic longint model_out(input int p);
        longint s = 0;
        for (int k = 0; k < K; k++) s += longint'(k * L + p + 1) * hist[k];
        return fmap(s, 16, 1'b1);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < K; k++) hist[k] = 0;
        rem = 0;
        exp_valid = 1'b0;
        exp_data = 0;
        exp_phase = 0;
    endtask

    // One clock: drive inputs, note o_ready, advance the model across the edge.
    task automatic step(input logic e, input logic v, input int d);
        @(negedge clk);
        ena = e;
        valid = v;
        data = d[7:0];
        #1;
        exp_ready = e && (rem <= 1);
        obs_ready = ready;
        @(posedge clk);
        if (e) begin
            if (rem > 0) begin
                exp_phase = L - rem;
                exp_data = model_out(exp_phase);
                exp_valid = 1'b1;
                rem--;
            end else begin
                exp_valid = 1'b0;
            end
            if (v && exp_ready) begin
                for (int k = K - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = d;
                rem += L;
            end
        end else begin
            exp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        valid = 1'b1;
        data = 8'sd5;
        sat_ena = 1'b1;
        sat_valid = 1'b1;
        sat_data = -8'sd128;
        model_clear();
        #12;
        n_checks++;
        if (ready !== 1'b0 || ovalid !== 1'b0 || odata !== 16'sd0 || ophase !== 2'd0 ||
            s_valid !== 1'b0 || s_data !== 12'sd0 || w_data !== 12'sd0) begin
            n_fail++;
            $display("FAIL reset: ready/valid/data/phase=%b/%b/%0d/%0d sat=%0d wrap=%0d, expected 0/0/0/0 sat=0 wrap=0",
                     ready, ovalid, odata, ophase, s_data, w_data);
        end
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_impulse();
        int samp [4] = '{1, 0, 0, 0};
        int idx = 0;
        int cnt = 0;
        logic v;
        for (int c = 0; c < 20; c++) begin
            v = (idx < 4) && (rem <= 1);
            step(1'b1, v, v ? samp[idx] : 0);
            if (v) idx++;
            n_checks++;
            if (ovalid !== exp_valid || odata !== 16'(exp_data) || ophase !== 2'(exp_phase) ||
                obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL impulse c%0d: v/d/p/rdy=%b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                         c, ovalid, odata, ophase, obs_ready, exp_valid, exp_data, exp_phase, exp_ready);
            end
            if (ovalid === 1'b1) begin
                n_checks++;
                if (int'(odata) !== cnt + 1 || int'(ophase) !== cnt % 4) begin
                    n_fail++;
                    $display("FAIL impulse_seq #%0d: data=%0d phase=%0d expected %0d/%0d",
                             cnt, odata, ophase, cnt + 1, cnt % 4);
                end
                cnt++;
            end
        end
        n_checks++;
        if (cnt !== 16) begin
            n_fail++;
            $display("FAIL impulse_count: got %0d outputs expected 16", cnt);
        end
    endtask

    task automatic test_back_to_back();
        int vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 1'b1, 1);
            n_checks++;
            if (ovalid !== exp_valid || odata !== 16'(exp_data) || ophase !== 2'(exp_phase) ||
                obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL b2b c%0d: v/d/p/rdy=%b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                         c, ovalid, odata, ophase, obs_ready, exp_valid, exp_data, exp_phase, exp_ready);
            end
            if (c >= 20) begin
                if (ovalid === 1'b1) vcnt++;
                n_checks++;
                if (int'(odata) !== 28 + 4 * int'(ophase)) begin
                    n_fail++;
                    $display("FAIL b2b_steady c%0d: data=%0d phase=%0d expected %0d",
                             c, odata, ophase, 28 + 4 * int'(ophase));
                end
            end
        end
        n_checks++;
        if (vcnt !== 20) begin
            n_fail++;
            $display("FAIL b2b_gapless: %0d valid cycles expected 20", vcnt);
        end
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 0);
    endtask

    task automatic test_enable_gap();
        logic e [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic v [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int s = $urandom_range(0, 255) - 128;
        for (int c = 0; c < 10; c++) begin
            step(e[c], v[c], (c == 0) ? s : 33);
            n_checks++;
            if (ovalid !== exp_valid || odata !== 16'(exp_data) || ophase !== 2'(exp_phase) ||
                obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL enable_gap c%0d: v/d/p/rdy=%b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                         c, ovalid, odata, ophase, obs_ready, exp_valid, exp_data, exp_phase, exp_ready);
            end
        end
    endtask

    task automatic test_rejection();
        logic v [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int d [10] = '{40, 0, 77, 0, 0, 0, 0, 0, 0, 0};
        for (int c = 0; c < 10; c++) begin
            step(1'b1, v[c], d[c]);
            n_checks++;
            if (ovalid !== exp_valid || odata !== 16'(exp_data) || ophase !== 2'(exp_phase) ||
                obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rejection c%0d: v/d/p/rdy=%b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                         c, ovalid, odata, ophase, obs_ready, exp_valid, exp_data, exp_phase, exp_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        step(1'b1, 1'b1, 9);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        @(negedge clk);
        valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || ovalid !== 1'b0 || odata !== 16'sd0 || ophase !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid: ready/valid/data/phase=%b/%b/%0d/%0d expected 0/0/0/0",
                     ready, ovalid, odata, ophase);
        end
        model_clear();
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, c == 0, 1);
            n_checks++;
            if (ovalid !== exp_valid || odata !== 16'(exp_data) || ophase !== 2'(exp_phase) ||
                obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL reset_resume c%0d: v/d/p/rdy=%b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                         c, ovalid, odata, ophase, obs_ready, exp_valid, exp_data, exp_phase, exp_ready);
            end
            if (ovalid === 1'b1) begin
                cnt++;
                n_checks++;
                if (int'(odata) !== cnt) begin
                    n_fail++;
                    $display("FAIL reset_resume_seq: data=%0d expected %0d", odata, cnt);
                end
            end
        end
    endtask

    task automatic test_saturation();
        bit found = 1'b0;
        longint es, ew;
        for (int c = 0; c < 20; c++) step(1'b1, 1'b0, 0);
        for (int c = 0; c < 8 && !found; c++) begin
            step(1'b1, 1'b0, 0);
            if (s_valid === 1'b1 && s_phase === 2'd3) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL sat_sync: phase 3 not seen in 8 cycles, last phase=%0d valid=%b", s_phase, s_valid);
        end
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 1'b0, 0);
            es = fmap(-128 * longint'(4 * p + 28), 12, 1'b1);
            ew = fmap(-128 * longint'(4 * p + 28), 12, 1'b0);
            n_checks++;
            if (s_valid !== 1'b1 || int'(s_phase) !== p || s_data !== 12'(es) ||
                w_valid !== 1'b1 || int'(w_phase) !== p || w_data !== 12'(ew)) begin
                n_fail++;
                $display("FAIL saturation p%0d: sat v/p/d=%b/%0d/%0d wrap v/p/d=%b/%0d/%0d expected sat %0d wrap %0d",
                         p, s_valid, s_phase, s_data, w_valid, w_phase, w_data, es, ew);
            end
        end
    endtask

    task automatic test_random();
        logic e, v;
        int d;
        for (int c = 0; c < 400; c++) begin
            e = ($urandom % 8) != 0;
            v = ($urandom % 2) != 0;
            d = (($urandom % 8) == 0) ? -128 : (int'($urandom_range(0, 255)) - 128);
            step(e, v, d);
            n_checks++;
            if (ovalid !== exp_valid || odata !== 16'(exp_data) || ophase !== 2'(exp_phase) ||
                obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL random c%0d: v/d/p/rdy=%b/%0d/%0d/%b expected %b/%0d/%0d/%b",
                         c, ovalid, odata, ophase, obs_ready, exp_valid, exp_data, exp_phase, exp_ready);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_impulse();
        test_back_to_back();
        test_enable_gap();
        test_rejection();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppi_mac_tdm.md
PPI_MAC_TDM -- requirements
Module: ppi_mac_tdm

Interface
REQ-001 SHALL have parameter gp_data_width, default 8, signed input sample width (DW).
REQ-002 SHALL have parameter gp_coeff_width, default 8, signed coefficient width (CW).
REQ-003 SHALL have parameter gp_interpolation_factor, default 4, phase count L (L >= 2).
REQ-004 SHALL have parameter gp_taps_per_phase, default 4, taps per phase K (K >= 1).
REQ-005 SHALL have parameter gp_coeff, default h[m]=m+1, packed L*K signed coefficients, h[m] at bits [m*CW +: CW].
REQ-006 SHALL have parameter gp_out_width, default 16, output width (OW).
REQ-007 SHALL have parameter gp_out_shift, default 0, arithmetic right shift applied to the accumulator.
REQ-008 SHALL have parameter gp_round, default 0; 1 = round half up before the shift, 0 = truncate.
REQ-009 SHALL have parameter gp_saturate, default 1; 1 = saturate to OW, 0 = two's-complement wrap.
REQ-010 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-011 SHALL have port i_rst_an  input  1  reset, asynchronous, active-low.
REQ-012 SHALL have port i_ena  input  1  clock enable.
REQ-013 SHALL have port i_valid  input  1  input sample valid.
REQ-014 SHALL have port i_data  input  DW  signed input sample.
REQ-015 SHALL have port o_ready  output  1  sample acceptance, combinational.
REQ-016 SHALL have port o_valid  output  1  output sample valid, registered.
REQ-017 SHALL have port o_data  output  OW  signed interpolated output, registered.
REQ-018 SHALL have port o_phase  output  clog2(L)  phase index of o_data, registered.

Function
REQ-019 SHALL implement states IDLE and RUN, plus a phase counter p in 0..L-1.
REQ-020 SHALL drive o_ready = i_ena & i_rst_an & (state==IDLE | (state==RUN & p==L-1)).
REQ-021 SHALL accept a sample on an edge where i_valid & o_ready: shift i_data into the K-deep delay line x[0..K-1] (x[0] newest), go to RUN, set p=0.
REQ-022 SHALL ignore i_valid when o_ready=0; the delay line stays unchanged.
REQ-023 SHALL, on each enabled edge in RUN, register o_data = f(sum_k h[k*L+p]*x[k]), o_phase=p, o_valid=1, and advance p.
REQ-024 SHALL, on the edge with p==L-1 and no accepted sample, go to IDLE; with an accepted sample, stay in RUN with p=0 (gapless output).
REQ-025 SHALL give the first output one enabled edge after the acceptance edge, and the L-th output L enabled edges after it.
REQ-026 SHALL use full-precision arithmetic: product DW+CW bits, accumulator DW+CW+clog2(K) bits, no intermediate loss.
REQ-027 SHALL compute f as: add 2^(gp_out_shift-1) if gp_round=1 and gp_out_shift>0; arithmetic right shift by gp_out_shift; then saturate to [-2^(OW-1), 2^(OW-1)-1] or wrap, per gp_saturate.
REQ-028 SHALL, on an edge with i_ena=0, clear o_valid and hold state, p, delay line, o_data and o_phase.
REQ-029 SHALL keep o_valid=0 on edges in IDLE, with o_data and o_phase holding their last values.

Reset
REQ-030 SHALL, on i_rst_an low and asynchronously, set state=IDLE, p=0, delay line=0, o_valid=0, o_data=0, o_phase=0.
REQ-031 SHALL, while i_rst_an is low, hold o_ready=0 and discard any in-progress burst; operation resumes from IDLE after release.

Verification (defaults: L=4, K=4, h[m]=m+1, DW=CW=8, OW=16)
REQ-032 SHALL cover impulse: 1 then three 0 samples, each at o_ready -> 16 outputs 1..16 in order, o_phase cycling 0..3.
REQ-033 SHALL cover back-to-back: i_valid held high, i_data=1 -> after fill, continuous o_valid with no gap, outputs 28,32,36,40 repeating.
REQ-034 SHALL cover saturation with OW=12, constant i_data=-128 steady state -> phase 0 gives -2048 and phase 3 gives -2048; with gp_saturate=0, phase 0 gives 512 and phase 3 gives -1024.
REQ-035 SHALL cover enable gap: i_ena low 3 cycles after the second output of a burst -> o_valid low during the gap, then phases 2,3 continue with the correct values.
REQ-036 SHALL cover rejection: i_valid pulse while o_ready=0 -> sample ignored, output sequence identical to the no-pulse case.
REQ-037 SHALL cover reset mid-burst: i_rst_an low after phase 1 -> all outputs 0 immediately, o_ready=0; the next accepted sample of 1 yields 1,2,3,4.
